// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci ASCII formatter: FSM states,
// the ASCII characters it emits, and a helper that sizes the BCD register.
package fib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SEND,
    SEND_CR,
    SEND_LF,
    SEND_ERR
  } state_t;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_E  = 8'h45;
  localparam logic [7:0] CHAR_R  = 8'h52;

  // Decimal digits needed for 2^w-1: floor(w*log10(2))+1, fixed-point log10(2).
  function automatic int digits_for(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads the binary value, then one
// add-3/shift step per cycle for DATA_W cycles; done pulses once after the last.
module bin2bcd_seq #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 10
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]   bin;
  logic [CNT_W-1:0]    cnt;
  logic [DIGITS*4-1:0] adj;

  // Per-digit correction so each digit stays 0..9 after the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[g*4 +: 4] = (bcd[g*4 +: 4] >= 4'd5) ? bcd[g*4 +: 4] + 4'd3
                                                   : bcd[g*4 +: 4];
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      bin  <= bin_in;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        {bcd, bin} <= {adj[DIGITS*4-2:0], bin, 1'b0};
        cnt        <= cnt + 1'b1;
        if (cnt == CNT_W'(DATA_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fib_ascii_formatter.sv
// Turns one 32-bit Fibonacci result (or error) into an ASCII decimal line
// ending in CR LF, streamed a byte at a time with downstream backpressure.
module fib_ascii_formatter
  import fib_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 10
) (
  input  logic              CLK,
  input  logic              RESET_n,
  output logic              ASI_READY,
  input  logic              ASI_VALID,
  input  logic [DATA_W-1:0] ASI_DATA,
  input  logic              ASI_ERROR,
  input  logic              ASO_READY,
  output logic              ASO_VALID,
  output logic [7:0]        ASO_DATA,
  output logic              ASO_EOP
);

  localparam int PTR_W = $clog2(DIGITS);

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt, msd;
  logic [1:0]          err_idx, err_idx_nxt;
  logic                valid_nxt, eop_nxt, ready_nxt;
  logic [7:0]          data_nxt;
  logic                conv_start, conv_busy, conv_done, xfer;
  logic [DIGITS*4-1:0] bcd;

  assign conv_start = (state == IDLE) && ASI_READY && ASI_VALID && !ASI_ERROR;
  assign xfer       = ASO_VALID && ASO_READY;

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bcd (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .start   (conv_start),
    .bin_in  (ASI_DATA),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (bcd)
  );

  function automatic logic [7:0] digit_char(input logic [DIGITS*4-1:0] b,
                                            input logic [PTR_W-1:0] p);
    return CHAR_0 + {4'h0, b[{p, 2'b00} +: 4]};
  endfunction

  // Highest nonzero digit; zero leaves the pointer at digit 0.
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[i*4 +: 4] != 4'd0) msd = PTR_W'(i);
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    err_idx_nxt = err_idx;
    valid_nxt   = ASO_VALID;
    data_nxt    = ASO_DATA;
    eop_nxt     = ASO_EOP;
    ready_nxt   = ASI_READY;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (ASI_READY && ASI_VALID) begin
          ready_nxt   = 1'b0;
          err_idx_nxt = '0;
          state_nxt   = ASI_ERROR ? SEND_ERR : CONV;
        end
      end
      CONV: begin
        if (conv_done && !conv_busy) begin
          state_nxt = SEND;
          ptr_nxt   = msd;
          valid_nxt = 1'b1;
          data_nxt  = digit_char(bcd, msd);
        end
      end
      SEND: begin
        if (xfer) begin
          if (ptr == '0) begin
            state_nxt = SEND_CR;
            data_nxt  = CHAR_CR;
          end else begin
            ptr_nxt  = ptr - 1'b1;
            data_nxt = digit_char(bcd, ptr - 1'b1);
          end
        end
      end
      SEND_ERR: begin
        // One idle cycle after acceptance before 'E' appears.
        if (!ASO_VALID) begin
          valid_nxt = 1'b1;
          data_nxt  = CHAR_E;
        end else if (xfer) begin
          if (err_idx == 2'd2) begin
            state_nxt = SEND_CR;
            data_nxt  = CHAR_CR;
          end else begin
            err_idx_nxt = err_idx + 1'b1;
            data_nxt    = CHAR_R;
          end
        end
      end
      SEND_CR: begin
        if (xfer) begin
          state_nxt = SEND_LF;
          data_nxt  = CHAR_LF;
          eop_nxt   = 1'b1;
        end
      end
      SEND_LF: begin
        if (xfer) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          data_nxt  = 8'h00;
          eop_nxt   = 1'b0;
          ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        data_nxt  = 8'h00;
        eop_nxt   = 1'b0;
        ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      ptr       <= '0;
      err_idx   <= '0;
      ASI_READY <= 1'b0;
      ASO_VALID <= 1'b0;
      ASO_DATA  <= 8'h00;
      ASO_EOP   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      err_idx   <= err_idx_nxt;
      ASI_READY <= ready_nxt;
      ASO_VALID <= valid_nxt;
      ASO_DATA  <= data_nxt;
      ASO_EOP   <= eop_nxt;
    end
  end

endmodule

// File: tb/tb_fib_ascii_formatter.sv
// Directed bench: table of requests with expected text lines, plus
// hand sequences for backpressure, ignored requests and mid-line reset.
module tb_fib_ascii_formatter;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        ASI_READY;
  logic        ASI_VALID = 1'b0;
  logic [31:0] ASI_DATA = '0;
  logic        ASI_ERROR = 1'b0;
  logic        ASO_READY = 1'b1;
  logic        ASO_VALID;
  logic [7:0]  ASO_DATA;
  logic        ASO_EOP;

  int n_cmp = 0;
  int n_err = 0;

  fib_ascii_formatter #(.DATA_W(32), .DIGITS(10)) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .ASI_READY (ASI_READY),
    .ASI_VALID (ASI_VALID),
    .ASI_DATA  (ASI_DATA),
    .ASI_ERROR (ASI_ERROR),
    .ASO_READY (ASO_READY),
    .ASO_VALID (ASO_VALID),
    .ASO_DATA  (ASO_DATA),
    .ASO_EOP   (ASO_EOP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        err;
    logic [31:0] data;
    logic [95:0] txt;   // right-aligned ASCII, len characters
    int          len;
    int          lat;   // edges after acceptance until first char valid
    bit          rnd;   // randomised ASO_READY
    bit          poke;  // pulse ASI_VALID during conversion
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic e, input logic [31:0] d);
    int w = 0;
    @(negedge CLK);
    while (!ASI_READY && w < 200) begin
      @(negedge CLK);
      w++;
    end
    chk("accept_ready", {31'd0, ASI_READY}, 32'd1);
    ASI_VALID = 1'b1;
    ASI_DATA  = d;
    ASI_ERROR = e;
    @(posedge CLK);
    #1;
    ASI_VALID = 1'b0;
    ASI_ERROR = 1'b0;
  endtask

  task automatic collect(input logic [95:0] txt, input int len, input int lat,
                         input bit rnd, input bit poke);
    int k = 0, got = 0, first = -1, last = 0;
    bit held = 0;
    logic [7:0] hd = '0;
    logic he = 1'b0;
    logic [7:0] exp_c;
    while (got < len && k < 3000) begin
      @(negedge CLK);
      ASO_READY = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (poke) begin
        ASI_VALID = (k >= 4 && k < 8);
        ASI_DATA  = 32'd7;
        if (k >= 4 && k < 8) chk("ready_low_in_conv", {31'd0, ASI_READY}, 32'd0);
      end
      if (held) begin
        chk("stall_valid", {31'd0, ASO_VALID}, 32'd1);
        chk("stall_data", {24'd0, ASO_DATA}, {24'd0, hd});
        chk("stall_eop", {31'd0, ASO_EOP}, {31'd0, he});
      end
      if (ASO_VALID) begin
        if (first < 0) begin
          first = k;
          chk("first_latency", k, lat);
        end
        if (ASO_READY) begin
          exp_c = txt[(len-1-got)*8 +: 8];
          chk($sformatf("byte%0d", got), {24'd0, ASO_DATA}, {24'd0, exp_c});
          chk($sformatf("eop%0d", got), {31'd0, ASO_EOP}, {31'd0, (got == len-1)});
          got++;
          last = k;
          held = 0;
        end else begin
          held = 1;
          hd = ASO_DATA;
          he = ASO_EOP;
        end
      end else begin
        held = 0;
      end
      @(posedge CLK);
      k++;
    end
    ASI_VALID = 1'b0;
    ASO_READY = 1'b1;
    if (got < len) chk("line_timeout", got, len);
    if (!rnd) chk("back_to_back", last - first, len - 1);
    @(negedge CLK);
    chk("idle_ready_after_lf", {31'd0, ASI_READY}, 32'd1);
    chk("idle_valid_after_lf", {31'd0, ASO_VALID}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_asi_ready"}, {31'd0, ASI_READY}, 32'd0);
    chk({tag, "_aso_valid"}, {31'd0, ASO_VALID}, 32'd0);
    chk({tag, "_aso_data"},  {24'd0, ASO_DATA}, 32'd0);
    chk({tag, "_aso_eop"},   {31'd0, ASO_EOP}, 32'd0);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge CLK);
    #2;
    RESET_n = 1'b0;
    #1;
    chk_reset_vals(tag);
    @(negedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;
    chk({tag, "_ready_before_edge"}, {31'd0, ASI_READY}, 32'd0);
    @(negedge CLK);
    chk({tag, "_ready_after_edge"}, {31'd0, ASI_READY}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd1,          "1\r\n",          3,  33, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'd2971215073, "2971215073\r\n", 12, 33, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'd0,          "0\r\n",          3,  33, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'hFFFFFFFF,   "4294967295\r\n", 12, 33, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'd12345,      "ERR\r\n",        5,  1,  1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'd144,        "144\r\n",        5,  33, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'd1000000000, "1000000000\r\n", 12, 33, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'd10,         "10\r\n",         4,  33, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 32'd0,          "ERR\r\n",        5,  1,  1'b1, 1'b0};
    vecs[9] = '{1'b0, 32'd89,         "89\r\n",         4,  33, 1'b1, 1'b1};

    #1;
    chk_reset_vals("reset");
    @(negedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;
    chk("ready_low_before_first_edge", {31'd0, ASI_READY}, 32'd0);
    @(negedge CLK);
    chk("ready_high_after_first_edge", {31'd0, ASI_READY}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      send_req(vecs[i].err, vecs[i].data);
      collect(vecs[i].txt, vecs[i].len, vecs[i].lat, vecs[i].rnd, vecs[i].poke);
    end

    // Reset in the middle of a conversion.
    send_req(1'b0, 32'd2971215073);
    repeat (10) @(negedge CLK);
    reset_pulse("rst_conv");
    send_req(1'b0, 32'd9);
    collect("9\r\n", 3, 33, 1'b0, 1'b0);

    // Reset in the middle of an output line, with a stall in progress.
    send_req(1'b0, 32'd2971215073);
    repeat (36) @(negedge CLK);
    ASO_READY = 1'b0;
    reset_pulse("rst_line");
    ASO_READY = 1'b1;
    send_req(1'b0, 32'd55);
    collect("55\r\n", 4, 33, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
